// File: rtl/sr_latch_cmd_seq.sv
// Command sequencer for a gated SR latch: debounces set/clear requests and issues gate pulses with S/R setup and hold.
// Optional latch readback check enabled by defining SR_LATCH_CMD_SEQ_READBACK_EN (adds Q_FB, P_FB, ERR).
module sr_latch_cmd_seq #(
   parameter int DEB_N   = 4,
   parameter int PULSE_W = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic SET_REQ,
   input  logic CLR_REQ,
`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
   input  logic Q_FB,
   input  logic P_FB,
   output logic ERR,
`endif
   output logic S,
   output logic R,
   output logic GATE,
   output logic BUSY,
   output logic STATE_EXP
);

   localparam logic [7:0] DEB_MAX = 8'(DEB_N);
   localparam logic [7:0] DEB_ARM = 8'(DEB_N - 1);
   localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

   state_e     state_q, state_d;
   logic [7:0] set_cnt_q, set_cnt_d;
   logic [7:0] clr_cnt_q, clr_cnt_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic       slot_v_q, slot_v_d;
   logic       slot_c_q, slot_c_d;
   logic       cmd_q, cmd_d;
   logic       exp_q, exp_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       gate_q, gate_d;
   logic       busy_q, busy_d;
   logic       set_acc, clr_acc;

   // A request is accepted exactly once, on the edge its counter reaches DEB_N.
   always_comb begin
      set_acc   = SET_REQ && (set_cnt_q == DEB_ARM);
      set_cnt_d = set_cnt_q;
      if (!SET_REQ)
         set_cnt_d = '0;
      else if (set_cnt_q != DEB_MAX)
         set_cnt_d = set_cnt_q + 8'd1;
   end

   always_comb begin
      clr_acc   = CLR_REQ && (clr_cnt_q == DEB_ARM);
      clr_cnt_d = clr_cnt_q;
      if (!CLR_REQ)
         clr_cnt_d = '0;
      else if (clr_cnt_q != DEB_MAX)
         clr_cnt_d = clr_cnt_q + 8'd1;
   end

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      cmd_d    = cmd_q;
      slot_v_d = slot_v_q;
      slot_c_d = slot_c_q;
      exp_d    = exp_q;
      case (state_q)
         IDLE: begin
            if (slot_v_q) begin
               cmd_d    = slot_c_q;
               slot_v_d = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            pcnt_d  = PW_LAST;
            state_d = PULSE;
         end
         PULSE: begin
            if (pcnt_q == '0) begin
               exp_d   = cmd_q;
               state_d = HOLD;
            end else begin
               pcnt_d = pcnt_q - 8'd1;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Slot write after the IDLE consume so a same-edge acceptance lands in the slot; clear beats set.
      if (clr_acc) begin
         slot_v_d = 1'b1;
         slot_c_d = 1'b0;
      end else if (set_acc) begin
         slot_v_d = 1'b1;
         slot_c_d = 1'b1;
      end
      busy_d = (state_d != IDLE);
      s_d    = busy_d && cmd_d;
      r_d    = busy_d && !cmd_d;
      gate_d = (state_d == PULSE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         set_cnt_q <= '0;
         clr_cnt_q <= '0;
         pcnt_q    <= '0;
         slot_v_q  <= 1'b0;
         slot_c_q  <= 1'b0;
         cmd_q     <= 1'b0;
         exp_q     <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         gate_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_cnt_q <= set_cnt_d;
         clr_cnt_q <= clr_cnt_d;
         pcnt_q    <= pcnt_d;
         slot_v_q  <= slot_v_d;
         slot_c_q  <= slot_c_d;
         cmd_q     <= cmd_d;
         exp_q     <= exp_d;
         s_q       <= s_d;
         r_q       <= r_d;
         gate_q    <= gate_d;
         busy_q    <= busy_d;
      end
   end

   assign S         = s_q;
   assign R         = r_q;
   assign GATE      = gate_q;
   assign BUSY      = busy_q;
   assign STATE_EXP = exp_q;

`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
   logic err_q, err_d;

   // Latch outputs are only trusted in HOLD, after the gate has closed on stable S/R.
   always_comb begin
      err_d = err_q;
      if (state_q == HOLD && ((Q_FB != cmd_q) || (P_FB == Q_FB)))
         err_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign ERR = err_q;
`endif

endmodule

// File: tb/tb_sr_latch_cmd_seq.sv
// Self-checking bench for sr_latch_cmd_seq: directed scenarios plus randomized requests against a phase-based reference model.
module tb_sr_latch_cmd_seq;

   localparam int DEB_N = 4;
   localparam int PW    = 2;

   logic CLK = 1'b0;
   logic RST, SET_REQ, CLR_REQ;
   logic S, R, GATE, BUSY, STATE_EXP;
`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
   logic Q_FB, P_FB, ERR;
   logic q_lat = 1'b0;
   logic bad_fb = 1'b0;
`endif

   sr_latch_cmd_seq #(.DEB_N(DEB_N), .PULSE_W(PW)) dut (
      .CLK(CLK), .RST(RST), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
      .Q_FB(Q_FB), .P_FB(P_FB), .ERR(ERR),
`endif
      .S(S), .R(R), .GATE(GATE), .BUSY(BUSY), .STATE_EXP(STATE_EXP)
   );

   always #5 CLK = ~CLK;

`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
   // Behavioural gated SR latch driven by the DUT, with an optional stuck-at-0 fault on Q.
   always @(GATE or S or R) begin
      if (GATE) begin
         if (S) q_lat = 1'b1;
         else if (R) q_lat = 1'b0;
      end
   end
   assign Q_FB = bad_fb ? 1'b0 : q_lat;
   assign P_FB = ~Q_FB;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: request run lengths, a pending slot, and a command phase index.
   // phase = -1 idle, 0 setup, 1..PW gate open, PW+1 hold.
   int run_s, run_c, phase;
   bit slot_v, slot_c, m_cmd, m_exp, m_err;
   bit prev_s, prev_r, prev_g;
   int gate_pulses, s_seen, r_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      run_s = 0; run_c = 0; phase = -1;
      slot_v = 0; slot_c = 0; m_cmd = 0; m_exp = 0; m_err = 0;
      prev_s = 0; prev_r = 0; prev_g = 0;
   endtask

   task automatic model_step();
      bit acc_s, acc_c;
      run_s = SET_REQ ? ((run_s < 1000) ? run_s + 1 : run_s) : 0;
      run_c = CLR_REQ ? ((run_c < 1000) ? run_c + 1 : run_c) : 0;
      acc_s = (run_s == DEB_N);
      acc_c = (run_c == DEB_N);
`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
      if (phase == PW + 1 && (Q_FB !== m_cmd || P_FB === Q_FB)) m_err = 1;
`endif
      if (phase < 0) begin
         if (slot_v) begin
            m_cmd = slot_c; slot_v = 0; phase = 0;
         end
      end else if (phase == PW + 1) begin
         phase = -1;
      end else begin
         phase++;
         if (phase == PW + 1) m_exp = m_cmd;
      end
      if (acc_c) begin
         slot_v = 1; slot_c = 0;
      end else if (acc_s) begin
         slot_v = 1; slot_c = 1;
      end
   endtask

   task automatic compare_all();
      bit busy;
      busy = (phase >= 0);
      chk("S", S, busy && m_cmd);
      chk("R", R, busy && !m_cmd);
      chk("GATE", GATE, phase >= 1 && phase <= PW);
      chk("BUSY", BUSY, busy);
      chk("STATE_EXP", STATE_EXP, m_exp);
`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
      chk("ERR", ERR, m_err);
`endif
      chk("inv_s_and_r", S & R, 0);
      if (GATE) begin
         chk("inv_s_stable", S, prev_s);
         chk("inv_r_stable", R, prev_r);
      end
      if (GATE && !prev_g) gate_pulses++;
      if (S) s_seen++;
      if (R) r_seen++;
      prev_s = S; prev_r = R; prev_g = GATE;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      compare_all();
   endtask

   // Called at a negedge; leaves the DUT idle with RST released at a negedge.
   task automatic reset_sync();
      RST = 1'b1;
      #1;
      model_reset();
      chk("rst_gate", GATE, 0);
      chk("rst_busy", BUSY, 0);
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
      RST = 1'b0;
   endtask

   task automatic run_pattern(input bit [31:0] sp, input bit [31:0] cp, input int n);
      gate_pulses = 0; s_seen = 0; r_seen = 0;
      for (int e = 1; e <= n; e++) begin
         SET_REQ = sp[e-1];
         CLR_REQ = cp[e-1];
         tick();
      end
      SET_REQ = 1'b0;
      CLR_REQ = 1'b0;
   endtask

   // Nominal latency from reset for DEB_N=4, PULSE_W=2 with SET_REQ high from edge 1.
   task automatic nominal_check(input string tag);
      SET_REQ = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk({tag, "_S"}, S, e >= 5 && e <= 8);
         chk({tag, "_GATE"}, GATE, e == 6 || e == 7);
         chk({tag, "_BUSY"}, BUSY, e >= 5 && e <= 8);
         chk({tag, "_EXP"}, STATE_EXP, e >= 8);
      end
      SET_REQ = 1'b0;
      tick();
   endtask

   initial begin
      RST = 1'b1; SET_REQ = 1'b0; CLR_REQ = 1'b0;
      model_reset();
      #1;
      chk("reset_S", S, 0);
      chk("reset_R", R, 0);
      chk("reset_GATE", GATE, 0);
      chk("reset_BUSY", BUSY, 0);
      chk("reset_EXP", STATE_EXP, 0);
      @(negedge CLK);
      RST = 1'b0;

      nominal_check("lat");

      run_pattern(32'h7, 32'h0, 14);
      chk("short_pulses", gate_pulses, 0);
      chk("short_s_seen", s_seen, 0);

      reset_sync();
      run_pattern(32'h3F, 32'h3F, 16);
      chk("both_pulses", gate_pulses, 1);
      chk("both_s_seen", s_seen, 0);
      chk("both_r_cycles", r_seen, PW + 2);
      chk("both_exp", STATE_EXP, 0);

      reset_sync();
      run_pattern(32'h1EF, 32'h3C, 24);
      chk("lww_pulses", gate_pulses, 2);
      chk("lww_r_seen", r_seen, 0);
      chk("lww_exp", STATE_EXP, 1);

      reset_sync();
      SET_REQ = 1'b1;
      begin
         int waited = 0;
         while (!GATE && waited < 20) begin
            tick();
            waited++;
         end
         chk("mid_wait_gate", GATE, 1);
      end
      @(posedge CLK);
      model_step();
      #2;
      RST = 1'b1;
      #1;
      chk("mid_rst_GATE", GATE, 0);
      chk("mid_rst_S", S, 0);
      chk("mid_rst_R", R, 0);
      chk("mid_rst_BUSY", BUSY, 0);
      model_reset();
      SET_REQ = 1'b0;
      @(negedge CLK);
      compare_all();
      RST = 1'b0;
      nominal_check("post_rst");

`ifdef SR_LATCH_CMD_SEQ_READBACK_EN
      reset_sync();
      bad_fb = 1'b1;
      run_pattern(32'hF, 32'h0, 12);
      chk("rb_err_set", ERR, 1);
      bad_fb = 1'b0;
      run_pattern(32'h0, 32'hF, 12);
      chk("rb_err_sticky", ERR, 1);
      reset_sync();
      chk("rb_err_cleared", ERR, 0);
      run_pattern(32'hF, 32'h0, 12);
      chk("rb_err_good", ERR, 0);
`endif

      reset_sync();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) SET_REQ = ~SET_REQ;
         if ($urandom_range(0, 5) == 0) CLR_REQ = ~CLR_REQ;
         if ($urandom_range(0, 499) == 0) reset_sync();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
